crop_sequencer: RTL
===================

# crop_sequencer

Sequential controller that applies a rectangular crop to a frame held in a byte-addressed RGB frame memory by overwriting every border pixel with white (0xFF per channel). It walks the frame in raster order, one pixel per cycle for interior pixels, and issues three single-byte writes (R, G, B) through a valid/ready write port for each border pixel. It sits between the control/host logic, which supplies the crop margins and a start pulse, and the frame memory write port.

## Interface
- WIDTH, 768, frame width in pixels
- HEIGHT, 512, frame height in pixels
- ADDR_W, 21, byte-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT*3
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a crop pass; sampled only in IDLE
- left, right, top, bottom  in  16 each  crop margins in pixels; latched on accepted start
- busy  out  1  high from the cycle after accepted start until the cycle done pulses (inclusive of last write)
- done  out  1  one-cycle pulse when the pass completes
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write when wr_valid && wr_ready
- wr_addr  out  ADDR_W  byte address of write
- wr_data  out  8  write data; always 0xFF while wr_valid
- px_written  out  20  number of border pixels fully written in the current/last pass

## Operation
- Addressing: row i (0 = top), column j, channel c (0=R,1=G,2=B); address = WIDTH*3*(HEIGHT-1-i) + 3*j + c (bottom-up row storage).
- Border test for pixel (i,j): i <= top OR i >= HEIGHT-bottom OR j <= left OR j >= WIDTH-right. Subtractions done in 18-bit signed; a negative result makes that term true for every row/column. Comparisons are inclusive exactly as written (margin 0 still whitens row 0 and column 0).
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE: busy=0; on start=1 latch margins, clear i, j, c, px_written, go to SCAN.
- SCAN (one cycle per pixel): evaluate border for (i,j). Border: go to WRITE with c=0. Interior: advance pixel (j+1, wrap to 0 with i+1 at j=WIDTH-1); if current pixel is last (i=HEIGHT-1, j=WIDTH-1) go to DONE.
- WRITE: wr_valid=1, wr_addr for (i,j,c). On handshake: c<2 -> c+1, stay; c=2 -> px_written+1, advance pixel, go to SCAN, or DONE if it was the last pixel.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while not in IDLE is ignored; margin input changes after the accepted start have no effect on the pass.

## Timing
- Reset values: state IDLE, busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0xFF, px_written=0, counters 0.
- All outputs registered. Accepted start at cycle T -> busy=1 and state SCAN on T+1.
- With wr_ready held 1: interior pixel costs 1 cycle, border pixel costs 4 (1 SCAN + 3 WRITE). Total busy cycles = N_interior + 4*N_border; done pulses the following cycle.
- Backpressure: while wr_valid=1 and wr_ready=0, wr_addr, wr_data and wr_valid hold stable; no counter advances. wr_valid never deasserts without a handshake except on reset.
- Reset asserted mid-pass: immediate return to reset values; no partial-write completion, no done pulse.
- px_written holds its final value in IDLE until the next accepted start.

## Test plan
- WIDTH=8, HEIGHT=4, all margins 0, wr_ready=1 -> 11 border pixels (row 0 + column 0 rows 1-3), 33 writes, first write addr 72 (row 0, j=0, R), busy 65 cycles, px_written=11, one done pulse.
- Same params, all margins 100 -> every pixel border, 96 writes covering addresses 0..95 exactly once, px_written=32.
- Margins left=1,right=2,top=0,bottom=1, wr_ready=1 -> border set matches formula (row 0, row 3, columns 0,1,6,7); check every address and that no interior address (e.g. i=1,j=2 -> addr 54..56) is written.
- wr_ready low 5 cycles during first write -> wr_addr/wr_data/wr_valid stable for all 5 cycles, total busy grows by exactly 5.
- start pulsed mid-pass with new margins -> ignored; pass result identical to undisturbed run.
- rst_n low during WRITE of a border pixel -> all outputs at reset values asynchronously, no done; fresh start afterwards yields full correct pass.

Source files
------------

// File: rtl/crop_wr_if.sv
// Byte-wide write port from the crop sequencer to the RGB frame memory.
interface crop_wr_if #(
  parameter int ADDR_W = 21
);
  // A write transfers on a rising edge where wr_valid && wr_ready. Once wr_valid
  // is raised, wr_valid/wr_addr/wr_data hold until that transfer; ready may toggle freely.
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/crop_sequencer.sv
// Raster-walks a bottom-up RGB frame and whitens every pixel outside the crop window,
// one cycle per interior pixel and three byte writes per border pixel.
module crop_sequencer #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] left,
  input  logic [15:0] right,
  input  logic [15:0] top,
  input  logic [15:0] bottom,
  output logic        busy,
  output logic        done,
  output logic [19:0] px_written,
  output logic [1:0]  dbg_state,
  crop_wr_if.master   wr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(WIDTH * 3);
  localparam logic [ADDR_W-1:0] ROW0_BASE = ADDR_W'(WIDTH * 3 * (HEIGHT - 1));
  localparam logic signed [17:0] W_S      = 18'(WIDTH);
  localparam logic signed [17:0] H_S      = 18'(HEIGHT);
  localparam logic [15:0]        LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [15:0]        LAST_COL = 16'(WIDTH - 1);

  state_t            state;
  logic [15:0]       row, col;
  logic [1:0]        chan;
  logic [15:0]       left_q, right_q, top_q, bottom_q;
  // Row base walks downward (bottom-up storage) and column offset by 3 per pixel,
  // so the pixel byte address is a single add with no multiplier.
  logic [ADDR_W-1:0] row_base, col_off;

  logic [15:0]       row_nx, col_nx;
  logic [ADDR_W-1:0] row_base_nx, col_off_nx;
  logic signed [17:0] row_s, col_s, bottom_lim, right_lim;
  logic              is_border, is_last;

  assign dbg_state = state;

  // A negative limit (margin wider than the frame) makes its term true everywhere.
  assign row_s      = $signed({2'b00, row});
  assign col_s      = $signed({2'b00, col});
  assign bottom_lim = H_S - $signed({2'b00, bottom_q});
  assign right_lim  = W_S - $signed({2'b00, right_q});
  assign is_border  = (row <= top_q) || (row_s >= bottom_lim) ||
                      (col <= left_q) || (col_s >= right_lim);
  assign is_last    = (row == LAST_ROW) && (col == LAST_COL);

  always_comb begin
    row_nx      = row;
    col_nx      = col + 16'd1;
    row_base_nx = row_base;
    col_off_nx  = col_off + ADDR_W'(3);
    if (col == LAST_COL) begin
      row_nx      = row + 16'd1;
      col_nx      = '0;
      row_base_nx = row_base - ROW_BYTES;
      col_off_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      px_written  <= '0;
      row         <= '0;
      col         <= '0;
      chan        <= '0;
      row_base    <= ROW0_BASE;
      col_off     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      top_q       <= '0;
      bottom_q    <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= 8'hFF;
    end else begin
      done       <= 1'b0;
      wr.wr_data <= 8'hFF;
      case (state)
        S_IDLE: begin
          if (start) begin
            left_q     <= left;
            right_q    <= right;
            top_q      <= top;
            bottom_q   <= bottom;
            row        <= '0;
            col        <= '0;
            chan       <= '0;
            row_base   <= ROW0_BASE;
            col_off    <= '0;
            px_written <= '0;
            busy       <= 1'b1;
            state      <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (is_border) begin
            chan        <= '0;
            wr.wr_valid <= 1'b1;
            wr.wr_addr  <= row_base + col_off;
            state       <= S_WRITE;
          end else begin
            row      <= row_nx;
            col      <= col_nx;
            row_base <= row_base_nx;
            col_off  <= col_off_nx;
            if (is_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_WRITE: begin
          if (wr.wr_ready) begin
            if (chan != 2'd2) begin
              chan       <= chan + 2'd1;
              wr.wr_addr <= wr.wr_addr + ADDR_W'(1);
            end else begin
              wr.wr_valid <= 1'b0;
              px_written  <= px_written + 20'd1;
              row         <= row_nx;
              col         <= col_nx;
              row_base    <= row_base_nx;
              col_off     <= col_off_nx;
              if (is_last) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_SCAN;
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
